// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU (op codes 12..15).
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration loop.
module div_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  operation,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [4:0] OP_DIV  = 5'd12;
  localparam logic [4:0] OP_DIVU = 5'd13;
  localparam logic [4:0] OP_REM  = 5'd14;
  localparam logic [4:0] OP_REMU = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  op_q;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] dvd_raw;
  logic [31:0] dvs_raw;
  logic        q_neg;
  logic        r_neg;

  logic        in_signed;
  logic        in_special;
  logic        accept;
  logic        finish;
  logic        early;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        q_signed;
  logic        q_is_rem;
  logic        q_zero;
  logic        q_ovf;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] fix_result;

`ifdef DIV_EARLY_OUT_EN
  assign early = 1'b1;
`else
  assign early = 1'b0;
`endif

  // Operand classification at the request boundary
  always_comb begin
    in_signed  = (operation == OP_DIV) || (operation == OP_REM);
    in_special = (divisor == '0) ||
                 (in_signed && dividend == 32'h8000_0000 && divisor == '1);
    accept     = (state == IDLE) && start && !flush &&
                 (operation >= OP_DIV) && (operation <= OP_REMU);
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = (early && in_special) ? FIX : RUN;
      end
      RUN: begin
        if (flush)
          state_nxt = IDLE;
        else if (cnt == 5'd31)
          state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        finish    = !flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    trial = {rem, quo[31]};
    diff  = trial - {1'b0, dvs};
  end

  // Special cases are judged on the raw registered operands, not the magnitudes
  always_comb begin
    q_signed = (op_q == OP_DIV) || (op_q == OP_REM);
    q_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
    q_zero   = (dvs_raw == '0);
    q_ovf    = q_signed && (dvd_raw == 32'h8000_0000) && (dvs_raw == '1);
    q_fix    = q_neg ? (~quo + 32'd1) : quo;
    r_fix    = r_neg ? (~rem + 32'd1) : rem;
    if (q_zero)
      fix_result = q_is_rem ? dvd_raw : '1;
    else if (q_ovf)
      fix_result = q_is_rem ? '0 : 32'h8000_0000;
    else
      fix_result = q_is_rem ? r_fix : q_fix;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      op_q    <= '0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      dvd_raw <= '0;
      dvs_raw <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (accept) begin
        op_q    <= operation;
        dvd_raw <= dividend;
        dvs_raw <= divisor;
        quo     <= (in_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
        dvs     <= (in_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;
        rem     <= '0;
        cnt     <= '0;
        q_neg   <= in_signed && (dividend[31] ^ divisor[31]);
        r_neg   <= in_signed && dividend[31];
      end else if (state == RUN && !flush) begin
        cnt <= cnt + 5'd1;
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= trial[31:0];
          quo <= {quo[30:0], 1'b0};
        end
      end
      if (finish)
        result <= fix_result;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table plus flush/reset/back-to-back sequences.
// Build with DIV_EARLY_OUT_EN defined to expect the short latency on special cases.
`timescale 1ns/1ps
module tb_div_sequencer;

  localparam logic [4:0] OP_DIV  = 5'd12;
  localparam logic [4:0] OP_DIVU = 5'd13;
  localparam logic [4:0] OP_REM  = 5'd14;
  localparam logic [4:0] OP_REMU = 5'd15;
  localparam int NORM_LAT = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  operation = '0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    bit          special;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .operation (operation),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    operation = op;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int t1;
    int t2;
    int dones;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0};
    vecs[3]  = '{OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   1'b0};
    vecs[4]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
    vecs[5]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b1};
    vecs[6]  = '{OP_REM,  32'h00001234,   32'd0,          32'h00001234,   1'b1};
    vecs[7]  = '{OP_DIVU, 32'h00001234,   32'd0,          32'hFFFFFFFF,   1'b1};
    vecs[8]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1'b1};
    vecs[9]  = '{OP_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0};
    vecs[10] = '{OP_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          1'b0};
    vecs[11] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0};
    vecs[12] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[13] = '{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0};
    vecs[14] = '{OP_DIV,  32'hFFFFFFF9,   32'hFFFFFFF9,   32'd1,          1'b0};
    vecs[15] = '{OP_REMU, 32'd3,          32'd5,          32'd3,          1'b0};
    vecs[16] = '{OP_REM,  32'hFFFFFF9C,   32'd0,          32'hFFFFFF9C,   1'b1};

    // Reset state
    #12;
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", result,      32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Vector table; the first start lands on the first edge with reset released
    for (int v = 0; v < 17; v++) begin
      issue(vecs[v].op, vecs[v].a, vecs[v].b);
      check($sformatf("v%0d_busy_after_start", v), 32'(busy), 32'd1);
      wait_done(lat);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].special ? SPEC_LAT : NORM_LAT));
      check($sformatf("v%0d_result", v), result, vecs[v].want);
      check($sformatf("v%0d_busy_at_done", v), 32'(busy), 32'd0);
      tick();
      check($sformatf("v%0d_done_single", v), 32'(done), 32'd0);
      check($sformatf("v%0d_result_held", v), result, vecs[v].want);
    end

    // Invalid op codes and flush+start in IDLE are dropped
    issue(5'd11, 32'd9, 32'd3);
    check("op11_ignored", 32'(busy), 32'd0);
    issue(5'd16, 32'd9, 32'd3);
    check("op16_ignored", 32'(busy), 32'd0);
    flush = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd3);
    flush = 1'b0;
    check("flush_start_idle", 32'(busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dones++;
    end
    check("ignored_no_done", 32'(dones), 32'd0);
    check("ignored_result", result, 32'hFFFFFF9C);

    // Flush mid-RUN with a start in the same cycle, then re-issue
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (14) tick();
    operation = OP_DIV;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    flush     = 1'b1;
    start     = 1'b1;
    tick();
    flush     = 1'b0;
    check("flush_run_busy", 32'(busy), 32'd0);
    check("flush_run_done", 32'(done), 32'd0);
    check("flush_run_result", result, 32'hFFFFFF9C);
    tick();
    start = 1'b0;
    check("reissue_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("reissue_latency", 32'(lat), 32'(NORM_LAT));
    check("reissue_result", result, 32'd100);

    // Start while busy does not disturb the operation in flight
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (5) tick();
    issue(OP_REMU, 32'd77, 32'd5);
    wait_done(lat);
    check("busy_start_latency", 32'(lat), 32'd27);
    check("busy_start_result", result, 32'd14);

    // Flush during FIX
    issue(OP_DIVU, 32'd9, 32'd3);
    repeat (32) tick();
    check("fix_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_fix_busy", 32'(busy), 32'd0);
    dones = 32'(done);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dones++;
    end
    check("flush_fix_no_done", 32'(dones), 32'd0);
    check("flush_fix_result", result, 32'd14);

    // Start held high: accepted in each done cycle's following edge
    operation = OP_DIVU;
    dividend  = 32'd9;
    divisor   = 32'd3;
    start     = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (done) begin
        if (t1 < 0) t1 = t;
        else begin
          t2 = t;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_first", 32'(t1), 32'd34);
    check("b2b_period", 32'(t2 - t1), 32'd34);
    check("b2b_result", result, 32'd3);

    // Asynchronous reset mid-RUN
    tick();
    issue(OP_DIV, 32'hFFFFFF9C, 32'd7);
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy",   32'(busy), 32'd0);
    check("rst_mid_done",   32'(done), 32'd0);
    check("rst_mid_result", result,    32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
